// File: rtl/sme_driver.sv
// sme_driver: host-side driver for a string matching engine.
// The host streams string or pattern packets. The driver buffers each packet,
// replays it to the matcher one character per cycle, and holds the matcher's
// verdict until the host takes it.
// Optional feature: define SME_DRIVER_TIMEOUT_EN to bound the wait for the
// matcher's result to TIMEOUT_CYC cycles. A wait that runs out reports res_err.
module sme_driver #(
  parameter int STR_MAX     = 32,
  parameter int PAT_MAX     = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_pat,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err
);

  // LW must hold the value STR_MAX itself, so it is one count wider than a buffer address.
  localparam int LW = $clog2(STR_MAX + 1);
  localparam int AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam logic [LW-1:0] STR_LIM = LW'(STR_MAX);
  localparam logic [LW-1:0] PAT_LIM = LW'(PAT_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, RESULT} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          pat_q, pat_d;
  logic          str_loaded_q, str_loaded_d;
  logic          res_match_q, res_match_d;
  logic [4:0]    res_index_q, res_index_d;
  logic          res_err_q, res_err_d;

  logic [7:0]    char_mem [STR_MAX];

  logic          xfer;
  logic          pat_sel;
  logic          no_string;
  logic          send_done;
  logic [LW-1:0] wr_idx;
  logic [LW-1:0] wr_lim;
  logic          wr_en;
  logic          timeout_hit;

  // Handshake and packet-level decode shared by the FSM and the datapath.
  always_comb begin
    xfer      = in_valid && in_ready;
    // in_pat is only meaningful on the first character of a packet.
    pat_sel   = (state_q == IDLE) ? in_pat : pat_q;
    no_string = pat_sel && !str_loaded_q;
    send_done = (state_q == SEND) && (idx_q == len_q - LW'(1));
    wr_idx    = (state_q == IDLE) ? '0 : len_q;
    wr_lim    = pat_sel ? PAT_LIM : STR_LIM;
    // Characters past the type's limit are dropped, and the length saturates.
    wr_en     = xfer && (wr_idx < wr_lim);
  end

`ifdef SME_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;

  // Count consecutive WAIT cycles without a result, and flag the final one.
  always_comb begin
    wait_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (state_q == WAIT && !valid) begin
      wait_cnt_d  = wait_cnt_q + TW'(1);
      timeout_hit = (wait_cnt_q == TW'(TIMEOUT_CYC - 1));
    end
  end

  // Register the wait-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  // Without the timeout, WAIT lasts until the matcher answers. The expression
  // is constant 0 but still references TIMEOUT_CYC in this build.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: begin
        if (xfer) begin
          if (in_last) state_d = no_string ? RESULT : SEND;
          else         state_d = LOAD;
        end
      end
      SEND:    if (send_done) state_d = pat_q ? WAIT : IDLE;
      WAIT:    if (valid || timeout_hit) state_d = RESULT;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Only in_ready needs the reset term: every other output is 0 in IDLE.
  always_comb begin
    in_ready  = reset && (state_q == IDLE || state_q == LOAD);
    isstring  = (state_q == SEND) && !pat_q;
    ispattern = (state_q == SEND) && pat_q;
    chardata  = (state_q == SEND) ? char_mem[idx_q[AW-1:0]] : 8'h00;
    res_valid = (state_q == RESULT);
    res_match = (state_q == RESULT) && res_match_q;
    res_index = (state_q == RESULT) ? res_index_q : 5'd0;
    res_err   = (state_q == RESULT) && res_err_q;
  end

  // Datapath next values: packet length, replay index, flags and the captured result.
  always_comb begin
    len_d        = len_q;
    idx_d        = '0;
    pat_d        = pat_q;
    str_loaded_d = str_loaded_q;
    res_match_d  = res_match_q;
    res_index_d  = res_index_q;
    res_err_d    = res_err_q;

    if (xfer) begin
      if (wr_en) len_d = wr_idx + LW'(1);
      if (state_q == IDLE) pat_d = in_pat;
      if (in_last && no_string) begin
        res_match_d = 1'b0;
        res_index_d = 5'd0;
        res_err_d   = 1'b1;
      end
    end

    if (state_q == SEND) idx_d = idx_q + LW'(1);
    if (send_done && !pat_q) str_loaded_d = 1'b1;

    if (state_q == WAIT) begin
      if (valid) begin
        res_match_d = match;
        res_index_d = match_index;
        res_err_d   = 1'b0;
      end else if (timeout_hit) begin
        res_match_d = 1'b0;
        res_index_d = 5'd0;
        res_err_d   = 1'b1;
      end
    end
  end

  // Datapath registers. The asynchronous reset clears everything, including any pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q        <= '0;
      idx_q        <= '0;
      pat_q        <= 1'b0;
      str_loaded_q <= 1'b0;
      res_match_q  <= 1'b0;
      res_index_q  <= 5'd0;
      res_err_q    <= 1'b0;
    end else begin
      len_q        <= len_d;
      idx_q        <= idx_d;
      pat_q        <= pat_d;
      str_loaded_q <= str_loaded_d;
      res_match_q  <= res_match_d;
      res_index_q  <= res_index_d;
      res_err_q    <= res_err_d;
    end
  end

  // Character buffer. No reset: contents are only read back below the valid length.
  always_ff @(posedge clk) begin
    if (wr_en) char_mem[wr_idx[AW-1:0]] <= in_data;
  end

endmodule
